exception_ctrl: RTL and testbench

Exception controller for the single-cycle LEGv8 datapath with exceptions: the producer side of the fetch stage's exception redirect interface (EProc_F / EVAddr_F). It observes synchronous exceptions from decode/execute, an asynchronous external interrupt and exception-return (ERET) instructions. It decides when fetch must be redirected and to which address, and holds the architectural exception state: return address, cause and handler mode.

---
 rtl/exception_ctrl_pkg.sv | 24 ++
 rtl/exception_ctrl_irq_sync.sv | 42 ++++
 rtl/exception_ctrl.sv | 136 +++++++++++++
 tb/tb_exception_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/exception_ctrl_pkg.sv
// Shared types and constants for the LEGv8 exception controller.
// Vector offsets are relative to the VEC_BASE parameter of the top.
package exc_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        HANDLER = 2'd1,
        DFAULT  = 2'd2
    } state_t;

    localparam logic [3:0]  EXC_ILLEGAL_ERET = 4'hE;

    localparam logic [11:0] OFF_SYNC   = 12'h000;
    localparam logic [11:0] OFF_IRQ    = 12'h080;
    localparam logic [11:0] OFF_DFAULT = 12'h100;

    localparam int          ESR_IRQ_BIT = 4;
    localparam int          CNT_W       = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/exception_ctrl_irq_sync.sv
// External interrupt front end: two-flop synchronizer, rising-edge detect
// and a sticky pending flag that only an accepted interrupt clears.
module irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_async,
    input  logic clr,
    output logic pending
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic pending_r;
    logic rise_s;

    assign rise_s  = sync2_r & ~prev_r;
    assign pending = pending_r;

    // Synchronizer chain, edge-detect history and pending flag.
    // A new edge in the same cycle as an accept must not be lost, so set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            prev_r    <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            sync1_r <= irq_async;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            if (rise_s) begin
                pending_r <= 1'b1;
            end else if (clr) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: decides fetch redirects and holds ELR/ESR, handler
// mode and a saturating count of exceptions taken.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int           N        = 64,
    parameter logic [N-1:0] VEC_BASE = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Exc_E,
    input  logic [3:0]   ExcCode_E,
    input  logic         ERet_E,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] NextPC_E,
    input  logic         ExtIRQ,
    output logic         EProc_F,
    output logic [N-1:0] EVAddr_F,
    output logic [N-1:0] ELR_o,
    output logic [N-1:0] ESR_o,
    output logic         InExc_o,
    output logic [7:0]   ExcCount_o
);

    localparam logic [N-1:0] VEC_SYNC   = VEC_BASE + N'(OFF_SYNC);
    localparam logic [N-1:0] VEC_IRQ    = VEC_BASE + N'(OFF_IRQ);
    localparam logic [N-1:0] VEC_DFAULT = VEC_BASE + N'(OFF_DFAULT);

    state_t             state_r;
    state_t             state_s;
    logic [N-1:0]       elr_r;
    logic [N-1:0]       elr_s;
    logic [N-1:0]       esr_r;
    logic [N-1:0]       esr_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               in_exc_r;
    logic               enter_s;
    logic               take_irq_s;
    logic               pending_s;
    logic               eproc_s;
    logic [N-1:0]       evaddr_s;

    irq_sync u_irq_sync (
        .clk       (clk),
        .rst_n     (reset),
        .irq_async (ExtIRQ),
        .clr       (take_irq_s),
        .pending   (pending_s)
    );

    // Redirect decision and next architectural state; Exc_E > ERet_E > IRQ.
    always_comb begin
        state_s    = state_r;
        elr_s      = elr_r;
        esr_s      = esr_r;
        enter_s    = 1'b0;
        take_irq_s = 1'b0;
        eproc_s    = 1'b0;
        evaddr_s   = {N{1'b0}};
        case (state_r)
            NORMAL: begin
                if (Exc_E || ERet_E) begin
                    // ERET outside a handler is reported as an illegal-return sync exception
                    eproc_s  = 1'b1;
                    evaddr_s = VEC_SYNC;
                    elr_s    = PC_E;
                    esr_s    = {{(N-4){1'b0}}, (Exc_E ? ExcCode_E : EXC_ILLEGAL_ERET)};
                    enter_s  = 1'b1;
                    state_s  = HANDLER;
                end else if (pending_s) begin
                    eproc_s    = 1'b1;
                    evaddr_s   = VEC_IRQ;
                    elr_s      = NextPC_E;
                    esr_s      = {N{1'b0}};
                    esr_s[ESR_IRQ_BIT] = 1'b1;
                    enter_s    = 1'b1;
                    take_irq_s = 1'b1;
                    state_s    = HANDLER;
                end else begin
                    state_s = NORMAL;
                end
            end
            HANDLER: begin
                if (Exc_E) begin
                    eproc_s  = 1'b1;
                    evaddr_s = VEC_DFAULT;
                    enter_s  = 1'b1;
                    state_s  = DFAULT;
                end else if (ERet_E) begin
                    eproc_s  = 1'b1;
                    evaddr_s = elr_r;
                    state_s  = NORMAL;
                end else begin
                    state_s = HANDLER;
                end
            end
            DFAULT: begin
                eproc_s  = 1'b1;
                evaddr_s = VEC_DFAULT;
                state_s  = DFAULT;
            end
            default: begin
                state_s = NORMAL;
            end
        endcase
    end

    // State, link/syndrome registers, handler flag and exception counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= NORMAL;
            elr_r    <= {N{1'b0}};
            esr_r    <= {N{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            in_exc_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            elr_r    <= elr_s;
            esr_r    <= esr_s;
            in_exc_r <= (state_s != NORMAL);
            if (enter_s) begin
                cnt_r <= sat_inc(cnt_r);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign EProc_F    = eproc_s;
    assign EVAddr_F   = evaddr_s;
    assign ELR_o      = elr_r;
    assign ESR_o      = esr_r;
    assign InExc_o    = in_exc_r;
    assign ExcCount_o = cnt_r;

endmodule

// File: tb/tb_exception_ctrl.sv
// Randomized and directed bench for exception_ctrl against a behavioural
// model of the redirect rules, IRQ timing and saturating counter.
module tb_exception_ctrl;

    localparam int          N  = 64;
    localparam logic [63:0] VB = 64'hFFFF_FFFF_FFFF_FF00;

    logic          clk;
    logic          reset;
    logic          exc;
    logic [3:0]    code;
    logic          eret;
    logic [63:0]   pc;
    logic [63:0]   npc;
    logic          ext;
    logic          eproc;
    logic [63:0]   evaddr;
    logic [63:0]   elr;
    logic [63:0]   esr;
    logic          inexc;
    logic [7:0]    cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: mode 0 normal, 1 handler, 2 double fault
    int          m_mode;
    logic [63:0] m_elr;
    logic [63:0] m_esr;
    int          m_cnt;
    bit          m_pend;
    bit          hist[$];

    exception_ctrl #(.N(N), .VEC_BASE(VB)) dut (
        .clk        (clk),
        .reset      (reset),
        .Exc_E      (exc),
        .ExcCode_E  (code),
        .ERet_E     (eret),
        .PC_E       (pc),
        .NextPC_E   (npc),
        .ExtIRQ     (ext),
        .EProc_F    (eproc),
        .EVAddr_F   (evaddr),
        .ELR_o      (elr),
        .ESR_o      (esr),
        .InExc_o    (inexc),
        .ExcCount_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_elr  = 64'h0;
        m_esr  = 64'h0;
        m_cnt  = 0;
        m_pend = 1'b0;
        hist   = {1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_redirect(output bit ep, output logic [63:0] va);
        ep = 1'b0;
        va = 64'h0;
        if (m_mode == 0) begin
            if (exc || eret) begin ep = 1'b1; va = VB; end
            else if (m_pend) begin ep = 1'b1; va = VB + 64'h80; end
        end else if (m_mode == 1) begin
            if (exc) begin ep = 1'b1; va = VB + 64'h100; end
            else if (eret) begin ep = 1'b1; va = m_elr; end
        end else begin
            ep = 1'b1;
            va = VB + 64'h100;
        end
    endtask

    task automatic model_edge();
        bit rise;
        bit taken;
        // ExtIRQ sampled at edge m-2 high and at m-3 low => pending at edge m
        rise  = hist[1] && !hist[2];
        taken = 1'b0;
        if (m_mode == 0) begin
            if (exc || eret) begin
                m_elr  = pc;
                m_esr  = exc ? {60'h0, code} : 64'hE;
                m_mode = 1;
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            end else if (m_pend) begin
                m_elr  = npc;
                m_esr  = 64'h10;
                m_mode = 1;
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
                taken  = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (exc) begin
                m_mode = 2;
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            end else if (eret) begin
                m_mode = 0;
            end
        end
        if (rise) m_pend = 1'b1;
        else if (taken) m_pend = 1'b0;
        hist.push_front(ext);
        hist.pop_back();
    endtask

    task automatic cyc();
        bit          ep;
        logic [63:0] va;
        @(negedge clk);
        model_redirect(ep, va);
        check_eq("EProc_F", {63'h0, eproc}, {63'h0, ep});
        check_eq("EVAddr_F", evaddr, va);
        @(posedge clk);
        model_edge();
        #1;
        check_eq("ELR_o", elr, m_elr);
        check_eq("ESR_o", esr, m_esr);
        check_eq("InExc_o", {63'h0, inexc}, {63'h0, (m_mode != 0)});
        check_eq("ExcCount_o", {56'h0, cnt}, 64'(m_cnt));
    endtask

    task automatic drive(input logic e, input logic [3:0] c, input logic r,
                         input logic [63:0] p, input logic [63:0] np);
        exc  = e;
        code = c;
        eret = r;
        pc   = p;
        npc  = np;
        cyc();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        exc = 1'b0; code = 4'h0; eret = 1'b0; ext = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("rst EProc_F", {63'h0, eproc}, 64'h0);
        check_eq("rst EVAddr_F", evaddr, 64'h0);
        check_eq("rst ELR_o", elr, 64'h0);
        check_eq("rst ESR_o", esr, 64'h0);
        check_eq("rst InExc_o", {63'h0, inexc}, 64'h0);
        check_eq("rst ExcCount_o", {56'h0, cnt}, 64'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        exc = 1'b0; code = 4'h0; eret = 1'b0; pc = 64'h0; npc = 64'h4; ext = 1'b0;
        model_reset();
        do_reset();
        repeat (5) drive(1'b0, 4'h0, 1'b0, 64'h10, 64'h14);

        // sync exception then return
        drive(1'b1, 4'h3, 1'b0, 64'h40, 64'h44);
        drive(1'b0, 4'h0, 1'b1, 64'h200, 64'h204);
        repeat (2) drive(1'b0, 4'h0, 1'b0, 64'h44, 64'h48);

        // single IRQ pulse, then no re-take without a new edge
        ext = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 64'h84, 64'h88);
        ext = 1'b0;
        repeat (4) drive(1'b0, 4'h0, 1'b0, 64'h84, 64'h88);
        drive(1'b0, 4'h0, 1'b1, 64'h300, 64'h304);
        repeat (6) drive(1'b0, 4'h0, 1'b0, 64'h88, 64'h8C);

        // IRQ edge while in handler, taken only after ERET
        drive(1'b1, 4'h7, 1'b0, 64'h90, 64'h94);
        ext = 1'b1;
        repeat (5) drive(1'b0, 4'h0, 1'b0, 64'h400, 64'h404);
        drive(1'b0, 4'h0, 1'b1, 64'h410, 64'h414);
        repeat (3) drive(1'b0, 4'h0, 1'b0, 64'h94, 64'h98);
        ext = 1'b0;
        drive(1'b0, 4'h0, 1'b1, 64'h500, 64'h504);

        // double fault held despite inputs, left only by reset
        drive(1'b1, 4'h2, 1'b0, 64'h60, 64'h64);
        drive(1'b1, 4'h9, 1'b0, 64'h600, 64'h604);
        for (int i = 0; i < 10; i++) begin
            ext = i[0];
            drive(i[1], 4'(i), 1'b1, 64'h700 + 64'(i), 64'h800);
        end
        do_reset();

        // illegal ERET in NORMAL, then Exc_E and ERet_E together
        drive(1'b0, 4'h0, 1'b1, 64'h20, 64'h24);
        drive(1'b0, 4'h0, 1'b1, 64'h900, 64'h904);
        drive(1'b1, 4'h5, 1'b1, 64'h28, 64'h2C);
        drive(1'b0, 4'h0, 1'b1, 64'h910, 64'h914);

        // counter saturation
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 4'h1, 1'b0, 64'h1000 + 64'(i), 64'h0);
            drive(1'b0, 4'h0, 1'b1, 64'h2000, 64'h0);
        end
        do_reset();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (($urandom_range(0, 9) == 0)) ext = ~ext;
            if ((m_mode == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 15) == 0, 4'($urandom), $urandom_range(0, 7) == 0,
                      {$urandom, $urandom}, {$urandom, $urandom});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
